rtc_ts_fifo: RTL
================

RTC_TS_FIFO -- requirements
Module: rtc_ts_fifo

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; power of two, at least 2.
REQ-002 Parameter WATERMARK, default 1: count_o threshold for irq_o, range 1..DEPTH.
REQ-003 clk_i  input  1  single clock for all logic.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 event_i  input  1  external timestamp trigger, asynchronous to clk_i.
REQ-006 en_i  input  1  capture enable.
REQ-007 cur_sec_i 6, cur_min_i 6, cur_hour_i 5, cur_mode_i 2, cur_day_of_week_i 3, cur_day_of_month_i 5, cur_month_i 4, cur_year_i 7  inputs  current time from the time counter.
REQ-008 pop_i  input  1  removes the head entry.
REQ-009 ovf_clr_i  input  1  clears overflow_o.
REQ-010 ts_valid_o  output  1  head entry present.
REQ-011 ts_sec_o … ts_year_o  outputs  same widths as REQ-007  head entry fields.
REQ-012 count_o  output  $clog2(DEPTH)+1  stored entries.
REQ-013 overflow_o  output  1  sticky, set when a capture is dropped.
REQ-014 irq_o  output  1  registered interrupt request.

Function
REQ-015 event_i SHALL pass through a 2-flop synchronizer; a capture pulse SHALL fire on a 0->1 transition of the synchronized (or filtered) level.
REQ-016 Without debounce, the entry SHALL be written at the 3rd clk_i edge sampling event_i high; count_o SHALL update at that edge.
REQ-017 The entry SHALL hold all eight cur_* inputs, sampled at the write edge, as a 38-bit word.
REQ-018 A capture with en_i low SHALL be discarded with no change to count_o or overflow_o; the synchronizer SHALL keep running.
REQ-019 The FIFO SHALL be first-word-fall-through, with ts_valid_o = (count_o != 0) and ts_*_o driven from the head entry.
REQ-020 pop_i with ts_valid_o high SHALL remove the head at that edge; pop_i while empty SHALL be ignored.
REQ-021 A capture while full without pop SHALL be dropped and set overflow_o at the same edge; FIFO contents SHALL be unchanged.
REQ-022 Capture and pop in the same cycle while full SHALL be accepted; count_o is unchanged and overflow_o is not set.
REQ-023 Capture and pop in the same cycle while empty SHALL ignore the pop and accept the capture.
REQ-024 ovf_clr_i SHALL clear overflow_o; a new overflow in the same cycle SHALL win, leaving overflow_o at 1.
REQ-025 Pointers SHALL wrap modulo DEPTH.
REQ-026 irq_o SHALL register (count_o >= WATERMARK) | overflow_o, one cycle after the causing edge.

Reset
REQ-027 With rst_i high at an edge: count_o=0, pointers=0, ts_valid_o=0, overflow_o=0, irq_o=0.
REQ-028 Reset SHALL set the synchronizer flops and the edge-detect register to 1, so an event_i held high through reset produces no capture.
REQ-029 Reset mid-operation SHALL discard all entries; ts_*_o are don't-care while ts_valid_o=0.

Configuration
REQ-030 Macro RTC_TS_DEBOUNCE_EN defined: the filtered level SHALL change only after the synchronized level differs from it on 4 consecutive edges.
REQ-031 With RTC_TS_DEBOUNCE_EN defined, the write SHALL occur at the 7th edge sampling event_i high, and pulses shorter than 4 cycles SHALL produce no capture.
REQ-032 Macro RTC_TS_DEBOUNCE_EN undefined: no filter; the behaviour of REQ-016 applies.

Verification
REQ-033 Reset, en_i=1, cur time 12:34:56, event_i high for 1 cycle -> count_o=1 after 3rd edge, ts_sec_o=56, ts_min_o=34, ts_hour_o=12, irq_o=1 one cycle later.
REQ-034 DEPTH=8, 9 separate events with no pops -> count_o=8, overflow_o=1, head equals first capture; then 8 pops -> entries in capture order, ts_valid_o=0.
REQ-035 Full FIFO, capture coinciding with pop -> count_o stays 8, overflow_o stays 0, new entry is last out.
REQ-036 overflow_o=1, ovf_clr_i and a dropped capture in the same cycle -> overflow_o=1; ovf_clr_i alone next cycle -> 0.
REQ-037 en_i=0 event -> no entry; event_i held high across rst_i deassertion -> no entry; with RTC_TS_DEBOUNCE_EN, a 3-cycle pulse -> no entry and a 4-cycle pulse -> one entry at the 7th edge.

Source files
------------

// File: rtl/rtc_ts_fifo.sv
// Timestamp capture FIFO: a synchronized event_i edge stores the current RTC time in a FWFT queue.
// Optional macro RTC_TS_DEBOUNCE_EN adds a 4-edge glitch filter on the synchronized event level.
module rtc_ts_fifo #(
    parameter int DEPTH     = 8,
    parameter int WATERMARK = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     event_i,
    input  logic                     en_i,
    input  logic [5:0]               cur_sec_i,
    input  logic [5:0]               cur_min_i,
    input  logic [4:0]               cur_hour_i,
    input  logic [1:0]               cur_mode_i,
    input  logic [2:0]               cur_day_of_week_i,
    input  logic [4:0]               cur_day_of_month_i,
    input  logic [3:0]               cur_month_i,
    input  logic [6:0]               cur_year_i,
    input  logic                     pop_i,
    input  logic                     ovf_clr_i,
    output logic                     ts_valid_o,
    output logic [5:0]               ts_sec_o,
    output logic [5:0]               ts_min_o,
    output logic [4:0]               ts_hour_o,
    output logic [1:0]               ts_mode_o,
    output logic [2:0]               ts_day_of_week_o,
    output logic [4:0]               ts_day_of_month_o,
    output logic [3:0]               ts_month_o,
    output logic [6:0]               ts_year_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] LP_WM    = CW'(WATERMARK);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic          w_level;
    logic          w_capture;

    // Reset to 1 so a level already high when reset releases is not seen as a new edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= event_i;
            r_sync2 <= r_sync1;
            r_prev  <= w_level;
        end
    end

`ifdef RTC_TS_DEBOUNCE_EN
    logic       r_filt;
    logic [1:0] r_db_cnt;

    // The filtered level follows only after four consecutive disagreeing samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_filt   <= 1'b1;
            r_db_cnt <= 2'd0;
        end else if (r_sync2 != r_filt) begin
            if (r_db_cnt == 2'd3) begin
                r_filt   <= r_sync2;
                r_db_cnt <= 2'd0;
            end else begin
                r_db_cnt <= r_db_cnt + 2'd1;
            end
        end else begin
            r_db_cnt <= 2'd0;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    assign w_capture = w_level & ~r_prev;

    logic [37:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_irq;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_req;
    logic          w_push;
    logic          w_drop;
    logic [37:0]   w_wdata;
    logic [37:0]   w_head;

    assign w_full  = (r_count == LP_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_pop   = pop_i & ~w_empty;
    assign w_req   = w_capture & en_i;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the capture.
    assign w_push  = w_req & (~w_full | w_pop);
    assign w_drop  = w_req & w_full & ~w_pop;
    assign w_wdata = {cur_year_i, cur_month_i, cur_day_of_month_i, cur_day_of_week_i,
                      cur_mode_i, cur_hour_i, cur_min_i, cur_sec_i};

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr_i) begin
                r_ovf <= 1'b0;
            end
            r_irq <= (r_count >= LP_WM) | r_ovf;
        end
    end

    assign w_head = r_mem[r_rd_ptr];
    assign {ts_year_o, ts_month_o, ts_day_of_month_o, ts_day_of_week_o,
            ts_mode_o, ts_hour_o, ts_min_o, ts_sec_o} = w_head;

    assign ts_valid_o = ~w_empty;
    assign count_o    = r_count;
    assign overflow_o = r_ovf;
    assign irq_o      = r_irq;
endmodule
